// File: rtl/reg_scan_pkg.sv
// rtl/reg_scan_pkg.sv - shared state encoding and mode constants for the register scan engine
package reg_scan_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_EMIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic MODE_DUMP    = 1'b0;
    localparam logic MODE_COMPARE = 1'b1;

endpackage

// File: rtl/reg_scan_settle_cnt.sv
// rtl/reg_scan_settle_cnt.sv - loadable settle down-counter with terminal flag
module reg_scan_settle_cnt #(
    parameter int Width = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [Width-1:0] loadValue,
    input  logic             dec,
    output logic [Width-1:0] count,
    output logic             zero
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // High on the cycle whose decrement lands on zero, so the caller leaves
    // SETTLE after exactly loadValue decrements.
    assign zero = dec && (count == Width'(1));

endmodule

// File: rtl/reg_scan_unit.sv
// rtl/reg_scan_unit.sv - register-file scan engine with dump and compare modes
module reg_scan_unit
    import reg_scan_pkg::*;
#(
    parameter int RegAddrBits  = 3,
    parameter int DataWidth    = 16,
    parameter int TotalReg     = 8,
    parameter int SettleCycles = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start,
    input  logic                         mode,
    output logic [RegAddrBits-1:0]       inr,
    input  logic [DataWidth-1:0]         out_value,
    input  logic [DataWidth-1:0]         exp_data,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [RegAddrBits-1:0]       dump_idx,
    output logic [DataWidth-1:0]         dump_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [$clog2(TotalReg+1)-1:0] fail_count,
    output logic [RegAddrBits-1:0]       first_fail_idx
);

    localparam int CntWidth  = $clog2(SettleCycles + 1);
    localparam int FailWidth = $clog2(TotalReg + 1);

    logic [2:0]           state;
    logic [2:0]           nextState;
    logic                 modeReg;
    logic [CntWidth-1:0]  settleCount;
    logic                 settleZero;
    logic                 lastIdx;
    logic                 sampleFail;
    logic                 advance;
    logic                 accept;
    logic                 cntLoad;
    logic [FailWidth-1:0] failCountNext;

    assign accept     = (state == ST_IDLE) && start;
    assign lastIdx    = (inr == RegAddrBits'(TotalReg - 1));
    assign sampleFail = (state == ST_SAMPLE) && (modeReg == MODE_COMPARE) && (out_value != exp_data);
    assign advance    = ((state == ST_SAMPLE) && (modeReg == MODE_COMPARE)) ||
                        ((state == ST_EMIT) && dump_ready);
    assign cntLoad    = accept || (advance && !lastIdx);
    assign failCountNext = sampleFail ? fail_count + 1'b1 : fail_count;

    reg_scan_settle_cnt #(
        .Width(CntWidth)
    ) u_settle_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cntLoad),
        .loadValue(CntWidth'(SettleCycles)),
        .dec      (state == ST_SETTLE),
        .count    (settleCount),
        .zero     (settleZero)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   if (start) nextState = ST_SETTLE;
            ST_SETTLE: if (settleZero) nextState = ST_SAMPLE;
            ST_SAMPLE: begin
                if (modeReg == MODE_DUMP) nextState = ST_EMIT;
                else                      nextState = lastIdx ? ST_DONE : ST_SETTLE;
            end
            ST_EMIT:   if (dump_ready) nextState = lastIdx ? ST_DONE : ST_SETTLE;
            ST_DONE:   nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        dump_valid = 1'b0;
        case (state)
            ST_SETTLE, ST_SAMPLE: busy = 1'b1;
            ST_EMIT: begin
                busy       = 1'b1;
                dump_valid = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            modeReg        <= MODE_DUMP;
            inr            <= '0;
            dump_idx       <= '0;
            dump_data      <= '0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
        end else begin
            if (accept) begin
                modeReg        <= mode;
                inr            <= '0;
                pass           <= 1'b0;
                fail_count     <= '0;
                first_fail_idx <= '0;
            end
            if (state == ST_SAMPLE) begin
                dump_data  <= out_value;
                dump_idx   <= inr;
                fail_count <= failCountNext;
                if (sampleFail && (fail_count == '0)) begin
                    first_fail_idx <= inr;
                end
            end
            if (advance && !lastIdx) begin
                inr <= inr + 1'b1;
            end
            // pass is set on entry to DONE so it is valid alongside the done pulse
            if (advance && lastIdx) begin
                pass <= (modeReg == MODE_COMPARE) && (failCountNext == '0);
            end
        end
    end

endmodule

// File: tb/tb_reg_scan_unit.sv
// tb/tb_reg_scan_unit.sv - directed self-checking bench for reg_scan_unit
module tb_reg_scan_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        mode;
    logic        dump_ready;
    logic [2:0]  inr;
    logic [15:0] out_value;
    logic [15:0] exp_data;
    logic        dump_valid;
    logic [2:0]  dump_idx;
    logic [15:0] dump_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  fail_count;
    logic [2:0]  first_fail_idx;

    logic        start4;
    logic        mode4;
    logic        ready4;
    logic [2:0]  inr4;
    logic [31:0] out4;
    logic [31:0] exp4;
    logic        valid4;
    logic [2:0]  idx4;
    logic [31:0] data4;
    logic        busy4;
    logic        done4;
    logic        pass4;
    logic [2:0]  failCount4;
    logic [2:0]  firstFail4;

    logic [15:0] regFile [8];
    logic [15:0] rom [8];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    assign out_value = regFile[inr];
    assign exp_data  = rom[inr];
    assign out4      = 32'hA5A5_0000 + {29'd0, inr4};
    assign exp4      = 32'hA5A5_0000 + {29'd0, inr4};

    reg_scan_unit u_dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .mode          (mode),
        .inr           (inr),
        .out_value     (out_value),
        .exp_data      (exp_data),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_idx      (dump_idx),
        .dump_data     (dump_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_count    (fail_count),
        .first_fail_idx(first_fail_idx)
    );

    reg_scan_unit #(
        .RegAddrBits (3),
        .DataWidth   (32),
        .TotalReg    (4),
        .SettleCycles(3)
    ) u_dut4 (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start4),
        .mode          (mode4),
        .inr           (inr4),
        .out_value     (out4),
        .exp_data      (exp4),
        .dump_valid    (valid4),
        .dump_ready    (ready4),
        .dump_idx      (idx4),
        .dump_data     (data4),
        .busy          (busy4),
        .done          (done4),
        .pass          (pass4),
        .fail_count    (failCount4),
        .first_fail_idx(firstFail4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare scan with optional stray start pulses at cycle pulseAt and in DONE.
    task automatic runCompare(input int pulseAt, output int doneCyc, output int doneCnt);
        @(negedge CLK);
        mode  = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        start   = 1'b0;
        mode    = 1'b0;
        doneCyc = 0;
        doneCnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                doneCnt++;
                if (doneCyc == 0) doneCyc = c;
            end
            start = (c == pulseAt) || (done && (pulseAt != 0));
            @(negedge CLK);
        end
        start = 1'b0;
    endtask

    initial begin
        int doneCyc;
        int doneCnt;
        int xfers;
        int stallLeft;
        logic [15:0] held;
        logic sawDone;

        RST        = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        dump_ready = 1'b1;
        start4     = 1'b0;
        mode4      = 1'b1;
        ready4     = 1'b1;
        regFile    = '{16'd0, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        rom        = '{16'd0, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

        repeat (2) @(negedge CLK);
        check("reset_inr",   32'(inr), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_valid", 32'(dump_valid), 32'd0);
        check("reset_pass",  32'(pass), 32'd0);
        check("reset_done",  32'(done), 32'd0);
        RST = 1'b1;

        runCompare(0, doneCyc, doneCnt);
        check("cmp_pass_done_cycle", 32'(doneCyc), 32'd17);
        check("cmp_pass_done_count", 32'(doneCnt), 32'd1);
        check("cmp_pass_pass",       32'(pass), 32'd1);
        check("cmp_pass_fail_count", 32'(fail_count), 32'd0);
        check("cmp_pass_first_fail", 32'(first_fail_idx), 32'd0);
        check("cmp_pass_idle",       32'(busy), 32'd0);

        rom[1] = 16'd4;
        rom[2] = 16'd5;
        runCompare(0, doneCyc, doneCnt);
        check("cmp_fail_done_cycle", 32'(doneCyc), 32'd17);
        check("cmp_fail_pass",       32'(pass), 32'd0);
        check("cmp_fail_fail_count", 32'(fail_count), 32'd2);
        check("cmp_fail_first_fail", 32'(first_fail_idx), 32'd1);
        rom[1] = 16'd3;
        rom[2] = 16'd4;

        @(negedge CLK);
        mode  = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start     = 1'b0;
        mode      = 1'b1;
        doneCyc   = 0;
        xfers     = 0;
        stallLeft = 3;
        held      = '0;
        for (int c = 1; c <= 60; c++) begin
            if (done && (doneCyc == 0)) doneCyc = c;
            if (dump_valid && (dump_idx == 3'd2) && (stallLeft > 0)) begin
                dump_ready = 1'b0;
                if (stallLeft == 3) held = dump_data;
                else check("dump_stall_stable", 32'(dump_data), 32'(held));
                stallLeft--;
            end else if (dump_valid) begin
                dump_ready = 1'b1;
                if (xfers < 8) begin
                    check("dump_idx",  32'(dump_idx), 32'(xfers));
                    check("dump_data", 32'(dump_data), 32'(regFile[xfers[2:0]]));
                end
                xfers++;
            end else begin
                dump_ready = 1'b1;
            end
            @(negedge CLK);
        end
        dump_ready = 1'b1;
        check("dump_stalled_value", 32'(held), 32'd4);
        check("dump_transfers",     32'(xfers), 32'd8);
        check("dump_done_cycle",    32'(doneCyc), 32'd28);
        check("dump_pass",          32'(pass), 32'd0);

        runCompare(5, doneCyc, doneCnt);
        check("ignored_start_done_cycle", 32'(doneCyc), 32'd17);
        check("ignored_start_done_count", 32'(doneCnt), 32'd1);
        check("ignored_start_idle",       32'(busy), 32'd0);

        @(negedge CLK);
        mode  = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (6) @(negedge CLK);
        check("rst_pre_inr",  32'(inr), 32'd3);
        check("rst_pre_busy", 32'(busy), 32'd1);
        RST = 1'b0;
        #1;
        check("rst_async_inr",   32'(inr), 32'd0);
        check("rst_async_busy",  32'(busy), 32'd0);
        check("rst_async_done",  32'(done), 32'd0);
        check("rst_async_valid", 32'(dump_valid), 32'd0);
        check("rst_async_data",  32'(dump_data), 32'd0);
        sawDone = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (done) sawDone = 1'b1;
        end
        check("rst_no_done", 32'(sawDone), 32'd0);
        RST = 1'b1;
        runCompare(0, doneCyc, doneCnt);
        check("rst_after_done_cycle", 32'(doneCyc), 32'd17);
        check("rst_after_pass",       32'(pass), 32'd1);

        @(negedge CLK);
        start4 = 1'b1;
        @(negedge CLK);
        start4  = 1'b0;
        doneCyc = 0;
        for (int c = 1; c <= 25; c++) begin
            if (c <= 16) check("param_inr_hold", 32'(inr4), 32'((c - 1) / 4));
            if (done4 && (doneCyc == 0)) doneCyc = c;
            @(negedge CLK);
        end
        check("param_done_cycle", 32'(doneCyc), 32'd17);
        check("param_pass",       32'(pass4), 32'd1);
        check("param_fail_count", 32'(failCount4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_scan_unit.md
# reg_scan_unit

Synthesizable register-file scan engine attached to the `Pipelined_Processor` debug read port (`inr` / `out_value`). On `start` it walks register indices 0 .. TotalReg-1, waits a programmable settle time per index, then samples the value. It either streams each (index, value) pair out over a valid/ready handshake (dump mode) or compares it against an expected-value ROM and reports pass/fail (compare mode). It sits beside the processor in the top-level test harness and replaces hand-sequenced `inr` sweeps with a parametrised, cycle-exact hardware scan.

## Interface
- `RegAddrBits`, 3, width of the register index.
- `DataWidth`, 16, register data width.
- `TotalReg`, 8, registers scanned. Must satisfy 1 ≤ TotalReg ≤ 2**RegAddrBits.
- `SettleCycles`, 1, cycles `inr` is held before `out_value` is sampled. Must be ≥ 1.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous assert, active-low.
- `start` in 1: begin a scan. Honoured only in IDLE.
- `mode` in 1: 0 = dump, 1 = compare. Latched on accepted `start`.
- `inr` out RegAddrBits: register index driven to the processor.
- `out_value` in DataWidth: register value returned by the processor.
- `exp_data` in DataWidth: expected value for the current `inr`, from an external combinational ROM.
- `dump_valid` out 1: dump word available.
- `dump_ready` in 1: consumer accepts the dump word.
- `dump_idx` out RegAddrBits: index of the dump word.
- `dump_data` out DataWidth: sampled register value.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at scan end.
- `pass` out 1: last compare scan had zero mismatches. Held until the next accepted `start`.
- `fail_count` out $clog2(TotalReg+1): mismatches in the last compare scan.
- `first_fail_idx` out RegAddrBits: index of the first mismatch. 0 if none.

## Operation
- States: IDLE, SETTLE, SAMPLE, EMIT, DONE.
- **IDLE**
  - On `start`: latch `mode`, set `inr`=0, set settle counter to SettleCycles.
  - Clear `pass`, `fail_count`, and `first_fail_idx`, then go to SETTLE.
- **SETTLE**
  - Decrement the counter each cycle.
  - After exactly SettleCycles cycles, go to SAMPLE.
- **SAMPLE** (one cycle)
  - Capture `out_value` into `dump_data` and set `dump_idx`=`inr`.
  - In compare mode, if `out_value` != `exp_data`:
    - Increment `fail_count`.
    - On the first mismatch only, record `inr` into `first_fail_idx`.
  - Dump mode: go to EMIT.
  - Compare mode: advance (see below).
- **EMIT**
  - `dump_valid`=1, with `dump_idx` and `dump_data` stable until `dump_ready`=1.
  - On the transfer cycle, advance.
- **Advance**
  - If `inr`==TotalReg-1, go to DONE.
  - Otherwise increment `inr`, reload the settle counter, and go to SETTLE.
  - `inr` never wraps.
- **DONE** (one cycle)
  - `done`=1.
  - In compare mode, `pass`=(`fail_count`==0). In dump mode, `pass`=0.
  - Return to IDLE.
- `start` outside IDLE is ignored. It neither restarts nor queues.
- `mode` changes mid-scan are ignored.
- Reset mid-scan: immediate return to IDLE, all outputs to reset values, and no `done` pulse.
- Reset values: every output is 0.
- `busy`=1 in SETTLE, SAMPLE, EMIT, and DONE.

## Timing
- `start` is accepted at clock edge E0.
- `inr` is valid from E0 and changes only when entering SETTLE.
- Compare mode:
  - Each index takes SettleCycles+1 cycles.
  - `done` is high in cycle 1 + TotalReg·(SettleCycles+1) after E0. With the defaults, that is cycle 17.
- Dump mode:
  - Each index takes SettleCycles+2 cycles, plus any `dump_ready` stall.
  - If `dump_ready` is tied high, `done` is high in cycle 1 + TotalReg·(SettleCycles+2).
- `exp_data` is sampled in the same cycle as `out_value` and corresponds to the current `inr`.
- `done` and `start` can coincide in DONE; that `start` is ignored. A new scan can begin one cycle after `done`.

## Structure
- Shared package `reg_scan_pkg` holds:
  - the state encoding localparams;
  - the mode constants MODE_DUMP and MODE_COMPARE.
- One natural sub-module, `reg_scan_settle_cnt`: a loadable down-counter of width $clog2(SettleCycles+1) with a `zero` flag.
- The FSM, compare logic, and output registers stay in `reg_scan_unit`.

## Test plan
- **Compare pass**
  - Processor runs ADDI $1,$0,3; JR $1; ADDI $1,$1,1; ADDI $2,$1,1; HALT.
  - ROM = {0,3,4,0,0,0,0,0}; compare mode.
  - Required: `done` at cycle 17, `pass`=1, `fail_count`=0.
- **Compare fail**
  - Same program; ROM entry 1 = 4 and entry 2 = 5.
  - Required: `pass`=0, `fail_count`=2, `first_fail_idx`=1.
- **Dump with backpressure**
  - Dump mode; `dump_ready` low for 3 cycles on index 2.
  - Required:
    - 8 transfers with idx 0..7 and data {0,3,4,0,...};
    - `dump_data` stable while stalled;
    - `done` at cycle 28.
- **Parametrised**
  - TotalReg=4, SettleCycles=3, DataWidth=32.
  - Required: `inr` holds each index for 4 cycles and `done` at cycle 17.
- **Ignored start**
  - Pulse `start` mid-scan and in DONE.
  - Required: no restart, and exactly one `done` per accepted `start`.
- **Reset mid-scan**
  - Assert `RST` low at cycle 7.
  - Required: all outputs 0 asynchronously, and a fresh `start` after release completes normally.
